// File: rtl/muldiv_iter_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift/add multiplier and restoring divider over a shared 2*WIDTH
// accumulator. Signed operations run on magnitudes, and the sign is fixed up
// in the final cycle. MTHI/MTLO write HI/LO directly from IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO commit here
// PREP  | take operand magnitudes, record signs, load accumulator
// RUN   | one shift/add or shift/subtract iteration per cycle
// FIX   | sign correction, HI/LO commit, done pulse
module muldiv_iter_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi0_lo1_sel,
   output logic [WIDTH-1:0] hilo_rd,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_MTHI = 2'b10;
   localparam logic [1:0] OP_MTLO = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   opa_q, opb_q;
   logic [2*WIDTH-1:0] acc_q, acc_step, prod_fix;
   logic               is_mul_q, sgn_q, neg_q, rneg_q, dz_q;
   logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
   logic               busy_q, done_q, dbz_q, busy_d, done_d, dbz_d;
   logic               launch, a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic [WIDTH-1:0]   rem_sub;
   logic               rem_ge;

   assign launch   = start && !flush && (op == OP_MUL || op == OP_DIV);
   // opb_q still holds the raw divisor/multiplier while in PREP
   assign a_neg    = sgn_q & opa_q[WIDTH-1];
   assign b_neg    = sgn_q & opb_q[WIDTH-1];
   assign mag_a    = a_neg ? -opa_q : opa_q;
   assign mag_b    = b_neg ? -opb_q : opb_q;
   assign prod_fix = neg_q ? -acc_q : acc_q;

   assign hilo_rd     = hi0_lo1_sel ? lo_q : hi_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic; flush wins over every in-flight state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (launch) state_d = S_PREP;
         S_PREP: state_d = S_RUN;
         S_RUN:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush && state_q != S_IDLE) state_d = S_IDLE;
   end

   // One multiply or divide iteration on the accumulator
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
      rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
      // a set top bit means the shifted remainder already exceeds any divisor
      rem_ge  = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= opb_q);
      rem_sub = rem_sh[WIDTH-1:0] - opb_q;
      if (is_mul_q) begin
         if (acc_q[0]) acc_step = {mul_sum, acc_q[WIDTH-1:1]};
         else          acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
      end else begin
         acc_step = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
      end
   end

   // Output and HI/LO next values
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_FIX) && !flush;
      dbz_d  = done_d && dz_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (state_q == S_IDLE && start && !flush) begin
         if (op == OP_MTHI)      hi_d = a;
         else if (op == OP_MTLO) lo_d = a;
      end
      if (done_d) begin
         if (is_mul_q) begin
            {hi_d, lo_d} = prod_fix;
         end else if (dz_q) begin
            hi_d = opa_q;
            lo_d = '1;
         end else begin
            lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Operand latch, preparation and iteration datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         is_mul_q <= 1'b0;
         sgn_q    <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (launch) begin
               opa_q    <= a;
               opb_q    <= b;
               is_mul_q <= (op == OP_MUL);
               sgn_q    <= signed_op;
            end
            S_PREP: begin
               opb_q  <= is_mul_q ? mag_a : mag_b;
               acc_q  <= {{WIDTH{1'b0}}, (is_mul_q ? mag_b : mag_a)};
               cnt_q  <= CNT_W'(WIDTH - 1);
               neg_q  <= a_neg ^ b_neg;
               rneg_q <= a_neg;
               dz_q   <= !is_mul_q && (opb_q == '0);
            end
            S_RUN: begin
               acc_q <= acc_step;
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Committed HI/LO and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         busy_q <= busy_d;
         done_q <= done_d;
         dbz_q  <= dbz_d;
      end
   end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit (WIDTH=32 main instance, WIDTH=8 regression).
module tb_muldiv_iter_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, signed_op, flush, sel;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [31:0] hilo_rd;
   logic        busy, done, dz;

   logic        start8, sgn8, sel8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8;
   logic [7:0]  hilo8;
   logic        busy8, done8, dz8;

   muldiv_iter_unit #(.WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .signed_op(signed_op),
      .a(a), .b(b), .flush(flush), .hi0_lo1_sel(sel), .hilo_rd(hilo_rd),
      .busy(busy), .done(done), .div_by_zero(dz)
   );

   muldiv_iter_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .signed_op(sgn8),
      .a(a8), .b(b8), .flush(1'b0), .hi0_lo1_sel(sel8), .hilo_rd(hilo8),
      .busy(busy8), .done(done8), .div_by_zero(dz8)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t rd_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor: compares HI/LO/div_by_zero on every done pulse, and serves read requests
   initial begin : monitor
      exp_t e;
      sel = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               sel = 1'b0; #1;
               chk({e.name, "_hi"}, {32'd0, hilo_rd}, {32'd0, e.hi});
               sel = 1'b1; #1;
               chk({e.name, "_lo"}, {32'd0, hilo_rd}, {32'd0, e.lo});
               chk({e.name, "_dz"}, {63'd0, dz}, {63'd0, e.dz});
            end
         end
         if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            sel = 1'b0; #1;
            chk({e.name, "_hi"}, {32'd0, hilo_rd}, {32'd0, e.hi});
            sel = 1'b1; #1;
            chk({e.name, "_lo"}, {32'd0, hilo_rd}, {32'd0, e.lo});
         end
      end
   end

   task automatic run_op(input string name, input logic [1:0] o, input logic s,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input bit b2b);
      exp_t e;
      int   cyc;
      e.hi = ehi; e.lo = elo; e.dz = edz; e.name = name;
      exp_q.push_back(e);
      if (!b2b) @(negedge clk);
      start = 1'b1; op = o; signed_op = s; a = av; b = bv;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      chk({name, "_busy_cycles"}, 64'(cyc), 64'd34);
   endtask

   task automatic quiet(input string name);
      @(negedge clk);
      chk({name, "_done_low"}, {63'd0, done}, 64'd0);
      chk({name, "_dz_low"},   {63'd0, dz},   64'd0);
      chk({name, "_busy_low"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic expect_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
      exp_t e;
      int   k;
      e.hi = ehi; e.lo = elo; e.dz = 1'b0; e.name = name;
      rd_q.push_back(e);
      k = 0;
      while (rd_q.size() > 0 && k < 10) begin
         @(negedge clk); #3;
         k++;
      end
      if (rd_q.size() > 0) begin
         chk({name, "_read_timeout"}, 64'd1, 64'd0);
         rd_q.delete();
      end
   endtask

   task automatic mt(input string name, input logic [1:0] o, input logic [31:0] v, input logic fl);
      @(negedge clk);
      start = 1'b1; op = o; a = v; flush = fl;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      chk({name, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cyc;
      start = 0; op = 0; signed_op = 0; a = 0; b = 0; flush = 0;
      start8 = 0; op8 = 0; sgn8 = 0; a8 = 0; b8 = 0; sel8 = 0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #3;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_dz",   {63'd0, dz},   64'd0);
      @(negedge clk); rst = 1'b1;
      expect_hilo("reset_hilo", 32'h0, 32'h0);

      run_op("multu_max", 2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
      quiet("multu_max");

      run_op("mult_neg", 2'b00, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
      run_op("div_neg_b2b", 2'b01, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
      quiet("div_neg");

      run_op("divu_zero", 2'b01, 1'b0, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0);
      quiet("divu_zero");
      run_op("div_min_m1", 2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0);
      quiet("div_min_m1");

      mt("mthi", 2'b10, 32'hCAFEBABE, 1'b0);
      mt("mtlo", 2'b11, 32'h0BADF00D, 1'b0);
      expect_hilo("mthi_mtlo", 32'hCAFEBABE, 32'h0BADF00D);

      // flush mid-RUN, with an ignored MTLO issued while busy
      @(negedge clk);
      start = 1'b1; op = 2'b00; signed_op = 1'b0; a = 32'd7; b = 32'd6;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         if (i == 5) begin start = 1'b1; op = 2'b11; a = 32'h11111111; end
         if (i == 6) start = 1'b0;
      end
      chk("flush_busy_before", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_busy_after", {63'd0, busy}, 64'd0);
      flush = 1'b0;
      repeat (40) @(negedge clk);
      expect_hilo("flush_hilo_kept", 32'hCAFEBABE, 32'h0BADF00D);

      // start together with flush in IDLE is ignored
      mt("flush_start_mthi", 2'b10, 32'hDEADBEEF, 1'b1);
      mt("flush_start_mul", 2'b00, 32'h3, 1'b1);
      expect_hilo("flush_start_hilo", 32'hCAFEBABE, 32'h0BADF00D);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; op = 2'b01; signed_op = 1'b0; a = 32'd100; b = 32'd3;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrst_busy_before", {63'd0, busy}, 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_hilo", {32'd0, hilo_rd}, 64'd0);
      @(negedge clk); rst = 1'b1;
      expect_hilo("midrst_hilo_both", 32'h0, 32'h0);
      quiet("midrst");

      // WIDTH=8 regression: DIVU 200/7
      @(negedge clk);
      start8 = 1'b1; op8 = 2'b01; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
      @(posedge clk); #1 start8 = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (busy8 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      chk("w8_busy_cycles", 64'(cyc), 64'd10);
      chk("w8_done", {63'd0, done8}, 64'd1);
      sel8 = 1'b1; #1;
      chk("w8_lo", {56'd0, hilo8}, 64'd28);
      sel8 = 1'b0; #1;
      chk("w8_hi", {56'd0, hilo8}, 64'd4);
      chk("w8_dz", {63'd0, dz8}, 64'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
